// File: rtl/dds_sweep_ctrl_if.sv
// Config channel of the DDS frequency-sweep sequencer: valid/ready handshake plus the sweep description.
interface dds_sweep_ctrl_if #(
    parameter int FREQ_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [FREQ_WIDTH-1:0] cfg_start;
    logic [FREQ_WIDTH-1:0] cfg_step;
    logic [CNT_WIDTH-1:0]  cfg_num_steps;
    logic [CNT_WIDTH-1:0]  cfg_dwell;
    logic                  cfg_repeat;

    modport master (
        output cfg_valid,
        output cfg_start,
        output cfg_step,
        output cfg_num_steps,
        output cfg_dwell,
        output cfg_repeat,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_start,
        input  cfg_step,
        input  cfg_num_steps,
        input  cfg_dwell,
        input  cfg_repeat,
        output cfg_ready
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS phase accumulator (FCW stepping, dwell, advance enable).
// Optional macro DDS_SWEEP_TRIANGLE_EN: repeat mode bounces between endpoints instead of sawtooth restart.
module dds_sweep_ctrl #(
    parameter int FREQ_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dds_sweep_ctrl_if.slave       cfg,
    input  logic                  start,
    input  logic                  abort,
    output logic [FREQ_WIDTH-1:0] freq_out,
    output logic                  freq_valid,
    output logic                  phase_ad_valid,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  step_idx,
    output logic                  sweep_done
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [FREQ_WIDTH-1:0] start_sh_q, start_sh_d;
    logic [FREQ_WIDTH-1:0] step_sh_q, step_sh_d;
    logic [CNT_WIDTH-1:0]  num_sh_q, num_sh_d;
    logic [CNT_WIDTH-1:0]  dwell_sh_q, dwell_sh_d;
    logic                  repeat_sh_q, repeat_sh_d;
    logic [FREQ_WIDTH-1:0] freq_q, freq_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  freq_valid_q, freq_valid_d;
    logic                  sweep_done_q, sweep_done_d;
`ifdef DDS_SWEEP_TRIANGLE_EN
    logic                  dir_down_q, dir_down_d;
`endif

    logic                  cfg_fire;
    logic                  point_end;
    logic [CNT_WIDTH-1:0]  dwell_eff;
    logic [CNT_WIDTH-1:0]  last_idx;

    // Zero-valued count fields behave as one point / one cycle.
    assign dwell_eff = (dwell_sh_q == CNT_ZERO) ? CNT_ONE : dwell_sh_q;
    assign last_idx  = (num_sh_q == CNT_ZERO) ? CNT_ZERO : (num_sh_q - CNT_ONE);
    assign cfg_fire  = cfg.cfg_valid & cfg_ready_q;
    assign point_end = (dwell_cnt_q == CNT_ONE) || (dwell_cnt_q == CNT_ZERO);

    always_comb begin
        state_d      = state_q;
        start_sh_d   = start_sh_q;
        step_sh_d    = step_sh_q;
        num_sh_d     = num_sh_q;
        dwell_sh_d   = dwell_sh_q;
        repeat_sh_d  = repeat_sh_q;
        freq_d       = freq_q;
        idx_d        = idx_q;
        dwell_cnt_d  = dwell_cnt_q;
        freq_valid_d = 1'b0;
        sweep_done_d = 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
        dir_down_d   = dir_down_q;
`endif

        if (cfg_fire) begin
            start_sh_d  = cfg.cfg_start;
            step_sh_d   = cfg.cfg_step;
            num_sh_d    = cfg.cfg_num_steps;
            dwell_sh_d  = cfg.cfg_dwell;
            repeat_sh_d = cfg.cfg_repeat;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                // Launch uses the config held before any same-cycle handshake.
                if (start && !abort) begin
                    state_d      = ST_RUN;
                    freq_d       = start_sh_q;
                    idx_d        = CNT_ZERO;
                    dwell_cnt_d  = dwell_eff;
                    freq_valid_d = 1'b1;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    dir_down_d   = 1'b0;
`endif
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_ARMED;
                end else if (!point_end) begin
                    dwell_cnt_d = dwell_cnt_q - CNT_ONE;
                end else begin
                    dwell_cnt_d = dwell_eff;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    if (dir_down_q) begin
                        freq_valid_d = 1'b1;
                        if (idx_q == CNT_ZERO) begin
                            sweep_done_d = 1'b1;
                            dir_down_d   = 1'b0;
                            freq_d       = freq_q + step_sh_q;
                            idx_d        = idx_q + CNT_ONE;
                        end else begin
                            freq_d = freq_q - step_sh_q;
                            idx_d  = idx_q - CNT_ONE;
                        end
                    end else
`endif
                    if (idx_q < last_idx) begin
                        freq_d       = freq_q + step_sh_q;
                        idx_d        = idx_q + CNT_ONE;
                        freq_valid_d = 1'b1;
                    end else begin
                        sweep_done_d = 1'b1;
                        if (!repeat_sh_q) begin
                            state_d = ST_DONE;
                        end else begin
                            freq_valid_d = 1'b1;
`ifdef DDS_SWEEP_TRIANGLE_EN
                            // A single-point sweep has nothing to bounce off; it just replays.
                            if (last_idx != CNT_ZERO) begin
                                dir_down_d = 1'b1;
                                freq_d     = freq_q - step_sh_q;
                                idx_d      = idx_q - CNT_ONE;
                            end else begin
                                freq_d = start_sh_q;
                                idx_d  = CNT_ZERO;
                            end
`else
                            freq_d = start_sh_q;
                            idx_d  = CNT_ZERO;
`endif
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_ARMED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_ARMED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_sh_q   <= '0;
            step_sh_q    <= '0;
            num_sh_q     <= '0;
            dwell_sh_q   <= '0;
            repeat_sh_q  <= 1'b0;
            freq_q       <= '0;
            idx_q        <= '0;
            dwell_cnt_q  <= '0;
            cfg_ready_q  <= 1'b0;
            freq_valid_q <= 1'b0;
            sweep_done_q <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_down_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            start_sh_q   <= start_sh_d;
            step_sh_q    <= step_sh_d;
            num_sh_q     <= num_sh_d;
            dwell_sh_q   <= dwell_sh_d;
            repeat_sh_q  <= repeat_sh_d;
            freq_q       <= freq_d;
            idx_q        <= idx_d;
            dwell_cnt_q  <= dwell_cnt_d;
            cfg_ready_q  <= cfg_ready_d;
            freq_valid_q <= freq_valid_d;
            sweep_done_q <= sweep_done_d;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_down_q   <= dir_down_d;
`endif
        end
    end

    assign cfg.cfg_ready    = cfg_ready_q;
    assign freq_out         = freq_q;
    assign step_idx         = idx_q;
    assign freq_valid       = freq_valid_q;
    assign sweep_done       = sweep_done_q;
    assign busy             = (state_q == ST_RUN);
    assign phase_ad_valid   = (state_q == ST_RUN);
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected FCW points and sweep_done pulses are queued per sweep
// from a point-index model and popped by a monitor whenever the DUT pulses freq_valid / sweep_done.
module tb_dds_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] freq_out;
    logic        freq_valid;
    logic        phase_ad_valid;
    logic        busy;
    logic [15:0] step_idx;
    logic        sweep_done;

    dds_sweep_ctrl_if #(.FREQ_WIDTH(32), .CNT_WIDTH(16)) cfg_if ();

    dds_sweep_ctrl #(.FREQ_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg            (cfg_if),
        .start          (start),
        .abort          (abort),
        .freq_out       (freq_out),
        .freq_valid     (freq_valid),
        .phase_ad_valid (phase_ad_valid),
        .busy           (busy),
        .step_idx       (step_idx),
        .sweep_done     (sweep_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] freq;
        logic [15:0] idx;
    } fv_t;

    fv_t fv_q[$];
    int  done_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Point index of the j-th point presented since start, from the sweep rules alone.
    function automatic int pt_idx(input int j, input int ne, input bit rep);
        int p;
        if (!rep) return j % ne;
`ifdef DDS_SWEEP_TRIANGLE_EN
        if (ne > 1) begin
            p = j % (2 * ne - 2);
            return (p < ne) ? p : (2 * ne - 2 - p);
        end
`endif
        p = j % ne;
        return p;
    endfunction

    function automatic bit pass_end(input int j, input int ne, input bit rep);
        int i;
        i = pt_idx(j, ne, rep);
        if (i == ne - 1) return 1'b1;
`ifdef DDS_SWEEP_TRIANGLE_EN
        if (rep && ne > 1 && i == 0 && j > 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        fv_t e;
        int  dc;
        if (freq_valid) begin
            if (fv_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL fv_unexpected: actual freq=%h idx=%0d at cyc %0d, required none", freq_out, step_idx, cyc);
            end else begin
                e = fv_q.pop_front();
                $display("fv   cyc=%0d freq=%h idx=%0d", cyc, freq_out, step_idx);
                chk("fv_cycle", 64'(cyc), 64'(e.cyc));
                chk("fv_freq", 64'(freq_out), 64'(e.freq));
                chk("fv_idx", 64'(step_idx), 64'(e.idx));
            end
        end
        if (sweep_done) begin
            if (done_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_unexpected: actual sweep_done=1 at cyc %0d, required none", cyc);
            end else begin
                dc = done_q.pop_front();
                $display("done cyc=%0d", cyc);
                chk("done_cycle", 64'(cyc), 64'(dc));
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic load_cfg(input logic [31:0] s, input logic [31:0] st, input int n, input int d, input bit rep);
        chk("cfg_ready_pre", 64'(cfg_if.cfg_ready), 64'd1);
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_start     = s;
        cfg_if.cfg_step      = st;
        cfg_if.cfg_num_steps = 16'(n);
        cfg_if.cfg_dwell     = 16'(d);
        cfg_if.cfg_repeat    = rep;
        @(negedge clk);
        cfg_if.cfg_valid     = 1'b0;
    endtask

    // cut>0: abort (or reset when use_rst) is held during cycle K+cut; poke: try a config write while running.
    task automatic sweep(input logic [31:0] s, input logic [31:0] st, input int n, input int d,
                         input bit rep, input int cut, input bit use_rst, input bit poke, input bit reload);
        int          ne, de, k, lim, ec;
        logic [31:0] last_f;
        fv_t         e;
        ne = (n == 0) ? 1 : n;
        de = (d == 0) ? 1 : d;
        if (reload) load_cfg(s, st, n, d, rep);
        chk("armed_ready", 64'(cfg_if.cfg_ready), 64'd1);
        k      = cyc;
        lim    = (cut > 0) ? (k + cut) : (k + ne * de + 1);
        last_f = s;
        for (int j = 0; j < 100000; j++) begin
            ec = k + 1 + j * de;
            if (!rep && j >= ne) break;
            if (ec > lim) break;
            e.cyc  = ec;
            e.idx  = 16'(pt_idx(j, ne, rep));
            e.freq = s + 32'(e.idx) * st;
            fv_q.push_back(e);
            last_f = e.freq;
            if (pass_end(j, ne, rep) && (ec + de <= lim)) done_q.push_back(ec + de);
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            cfg_if.cfg_valid     = 1'b1;
            cfg_if.cfg_start     = ~s;
            cfg_if.cfg_step      = 32'h0BAD_0BAD;
            cfg_if.cfg_num_steps = 16'd9;
            cfg_if.cfg_dwell     = 16'd7;
            cfg_if.cfg_repeat    = 1'b1;
            chk("ready_in_run", 64'(cfg_if.cfg_ready), 64'd0);
            @(negedge clk);
            cfg_if.cfg_valid = 1'b0;
        end
        if (cut > 0) begin
            goto(k + cut);
            if (use_rst) rst_n = 1'b0;
            else abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("stop_busy", 64'(busy), 64'd0);
            chk("stop_phase", 64'(phase_ad_valid), 64'd0);
            if (use_rst) begin
                chk("rst_freq", 64'(freq_out), 64'd0);
                chk("rst_idx", 64'(step_idx), 64'd0);
                chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd0);
                chk("rst_fv", 64'(freq_valid), 64'd0);
                chk("rst_done", 64'(sweep_done), 64'd0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_ready_after", 64'(cfg_if.cfg_ready), 64'd1);
            end else begin
                chk("abort_freq_hold", 64'(freq_out), 64'(last_f));
                chk("abort_ready", 64'(cfg_if.cfg_ready), 64'd1);
            end
        end else begin
            goto(k + ne * de);
            chk("last_run_busy", 64'(busy), 64'd1);
            chk("last_run_phase", 64'(phase_ad_valid), 64'd1);
            @(negedge clk);
            chk("done_busy", 64'(busy), 64'd0);
            chk("done_phase", 64'(phase_ad_valid), 64'd0);
            chk("done_ready", 64'(cfg_if.cfg_ready), 64'd0);
            chk("done_freq_hold", 64'(freq_out), 64'(last_f));
            @(negedge clk);
            chk("armed_after_done", 64'(cfg_if.cfg_ready), 64'd1);
            chk("armed_phase", 64'(phase_ad_valid), 64'd0);
        end
        repeat (2) @(negedge clk);
        chk("sb_fv_drain", 64'(fv_q.size()), 64'd0);
        chk("sb_done_drain", 64'(done_q.size()), 64'd0);
        fv_q.delete();
        done_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, d, ne, de, cut;
        bit          rep;
        logic [31:0] s, st;

        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_start     = '0;
        cfg_if.cfg_step      = '0;
        cfg_if.cfg_num_steps = '0;
        cfg_if.cfg_dwell     = '0;
        cfg_if.cfg_repeat    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_freq", 64'(freq_out), 64'd0);
        chk("reset_idx", 64'(step_idx), 64'd0);
        chk("reset_fv", 64'(freq_valid), 64'd0);
        chk("reset_phase", 64'(phase_ad_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(sweep_done), 64'd0);
        chk("reset_ready", 64'(cfg_if.cfg_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(cfg_if.cfg_ready), 64'd1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_without_cfg", 64'(busy), 64'd0);

        sweep(32'h0100_0000, 32'h0010_0000, 4, 3, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        sweep(32'h0100_0000, 32'h0010_0000, 4, 3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        sweep(32'h0000_0005, 32'h0000_1234, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        sweep(32'hFFFF_FFF0, 32'h0000_0020, 2, 1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        sweep(32'h0000_0100, 32'hFFFF_FFF0, 2, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        sweep(32'h0040_0000, 32'h0000_1000, 3, 2, 1'b1, 20, 1'b0, 1'b0, 1'b1);
        sweep(32'h0000_2000, 32'h0000_0010, 4, 3, 1'b0, 6, 1'b0, 1'b0, 1'b1);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        chk("start_abort_ready", 64'(cfg_if.cfg_ready), 64'd1);
        @(negedge clk);
        chk("start_abort_busy2", 64'(busy), 64'd0);

        sweep(32'h0000_7000, 32'h0000_0100, 3, 2, 1'b1, 9, 1'b1, 1'b0, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_after_rst", 64'(busy), 64'd0);
        @(negedge clk);
        chk("start_after_rst2", 64'(busy), 64'd0);

        for (int it = 0; it < 30; it++) begin
            n   = int'($urandom_range(0, 5));
            d   = int'($urandom_range(0, 3));
            rep = 1'($urandom_range(0, 1));
            s   = $urandom;
            st  = ($urandom_range(0, 1) == 1) ? $urandom : (32'd0 - 32'($urandom_range(1, 1000)));
            ne  = (n == 0) ? 1 : n;
            de  = (d == 0) ? 1 : d;
            if (rep) cut = int'($urandom_range(1, 3 * ne * de + 3));
            else if ($urandom_range(0, 2) == 0) cut = int'($urandom_range(1, ne * de));
            else cut = 0;
            sweep(s, st, n, d, rep, cut, 1'b0, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
